regfile_mp: RTL
===============

Name: regfile_mp

Overview:
- Parametrised multi-port integer register file with registered read outputs, for the decode/register-read stage of the pipeline.
- Generalises width, depth and read/write port counts.
- Adds configurable same-cycle write-to-read bypass, a stall hold and a per-register pending-write scoreboard.
- Read data and busy flags are presented one cycle after the address, aligned with the next pipeline stage.

Parameters:
XLEN, 32, data width of each register
NREGS, 32, number of architectural registers (power of two, >= 2)
NREAD, 2, number of read ports
NWRITE, 1, number of write ports (1..2)
BYPASS, 1, 1 = read returns the same-cycle write data (write-first); 0 = read returns the pre-write value
ZERO_REG, 1, 1 = register 0 reads as zero, ignores writes and is never busy

Ports:
Clock  in  1  rising-edge clock
Reset  in  1  synchronous, active-high reset
Stall  in  1  hold read outputs
Flush  in  1  zero read outputs (bubble)
Raddr  in  NREAD*AW  read addresses, port p at [p*AW +: AW]
Rdata  out  NREAD*XLEN  registered read data
Rbusy  out  NREAD  registered pending-write flag per read port
Wreg  in  NWRITE  write enables
Rd  in  NWRITE*AW  write addresses
Wdata  in  NWRITE*XLEN  write data
Issue  in  1  mark IssueRd pending
IssueRd  in  AW  destination being issued
SbClear  in  1  clear entire scoreboard

Behaviour:
- Clocking and reset: single clock `Clock`. `Reset` is synchronous and active-high. AW = clog2(NREGS).
- Reset: on a rising edge with Reset=1, all registers, scoreboard bits, Rdata and Rbusy become 0. Reset overrides every other input.
- Writes:
  - Effective write for port w = Wreg[w] && !(ZERO_REG && Rd[w]==0).
  - Writes commit at the edge regardless of Stall and Flush.
  - If both write ports target the same register, port NWRITE-1 wins.
- Read register priority (registered outputs): Reset > Flush > Stall > load.
  - Flush: Rdata=0, Rbusy=0.
  - Stall (Flush=0): Rdata and Rbusy hold their values.
  - Load: Rdata[p] <= value(Raddr[p]); Rbusy[p] <= busy_next[Raddr[p]].
- value(a):
  - 0 if ZERO_REG and a==0.
  - Else, if BYPASS=1 and an effective write to a occurs this cycle, that write's data (highest port wins).
  - Else regs[a] before the edge.
- Latency: address at edge N, data valid after edge N+1. With BYPASS=1, a same-cycle write is visible with this latency. With BYPASS=0, it is visible one cycle later.
- Scoreboard: busy[NREGS] bits; busy_next is computed in this order:
  - Start from busy.
  - Clear bits for effective writes.
  - Set busy[IssueRd] if Issue && !(ZERO_REG && IssueRd==0). Set beats clear on the same register in the same cycle (the newer producer wins).
  - If SbClear, busy_next = 0 (overrides set and clear).
  - The scoreboard is unaffected by Stall and Flush.
- Boundary conditions:
  - Out-of-range addresses cannot occur (NREGS is a power of two).
  - With ZERO_REG=0, register 0 is an ordinary register.
  - Reset asserted mid-stall returns all outputs to 0 on the next edge.
  - Stall and Flush together: Flush wins.

Decomposition:
- Package regfile_pkg: function clog2-style AW helper; localparam default XLEN/NREGS; typedef for a packed address vector per port.
- Natural sub-module `regfile_scoreboard`: busy-bit array with set/clear/SbClear priority and combinational busy_next lookup per read port.
- Storage, bypass mux and output registers stay in the top module.

Test Plan:
1. Reset then read: Reset=1 for 1 edge; Raddr={3,5} -> Rdata={0,0} and Rbusy=0 after the next edge.
2. Write then read, BYPASS=1: Wreg=1, Rd=5, Wdata=0xDEADBEEF, Raddr[0]=5 in the same cycle -> Rdata[0]=0xDEADBEEF after that edge.
   - Same stimulus with BYPASS=0 -> 0 after that edge, then 0xDEADBEEF one edge later.
3. Zero register: write Rd=0, Wdata=0x1234; Issue with IssueRd=0; then read 0 -> Rdata=0, Rbusy=0.
   - With ZERO_REG=0 -> Rdata=0x1234, Rbusy=1.
4. Stall/Flush: load Rdata[1]=0xA5A5A5A5; Stall=1 while Raddr changes -> Rdata[1] stays 0xA5A5A5A5; Stall=1 and Flush=1 -> Rdata[1]=0.
   - A write issued during the stall is readable after release.
5. Scoreboard: Issue with IssueRd=7 -> Rbusy=1 on a read of 7.
   - Write Rd=7 and Issue with IssueRd=7 in the same cycle -> still busy.
   - Write Rd=7 alone -> Rbusy=0; SbClear clears all bits.
6. Dual write (NWRITE=2): both ports write register 9, port0=0x11, port1=0x22 -> a read of 9 returns 0x22.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port register file.
//   addr_width() : number of address bits needed to index n registers (min 1)
//   DEF_XLEN     : default data width
//   DEF_NREGS    : default register count
//   addr_t       : packed address for one port at the default depth
package regfile_pkg;

  localparam int unsigned DEF_XLEN  = 32;
  localparam int unsigned DEF_NREGS = 32;

  function automatic int unsigned addr_width(input int unsigned n);
    int unsigned w;
    w = 1;
    while ((32'd1 << w) < n) w++;
    return w;
  endfunction

  localparam int unsigned DEF_AW = addr_width(DEF_NREGS);

  typedef logic [DEF_AW-1:0] addr_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one busy bit per architectural register.
// busy_next applies, in increasing priority: effective-write clears, issue
// set (newer producer beats a same-cycle retire), then a global clear.
// Ports:
//   i_clk, i_rst     clock, synchronous active-high reset
//   i_wen, i_waddr   effective write enables / addresses (clear bits)
//   i_issue, i_issue_rd  mark a destination pending
//   i_sb_clear       clear the whole scoreboard
//   i_raddr          read addresses, port p at [p*AW +: AW]
//   o_rbusy_next     busy_next looked up at each read address
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned NREGS    = DEF_NREGS,
  parameter int unsigned NREAD    = 2,
  parameter int unsigned NWRITE   = 1,
  parameter bit          ZERO_REG = 1'b1,
  parameter int unsigned AW       = addr_width(NREGS)
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [NWRITE-1:0]     i_wen,
  input  logic [NWRITE*AW-1:0]  i_waddr,
  input  logic                  i_issue,
  input  logic [AW-1:0]         i_issue_rd,
  input  logic                  i_sb_clear,
  input  logic [NREAD*AW-1:0]   i_raddr,
  output logic [NREAD-1:0]      o_rbusy_next
);

  logic [NREGS-1:0] r_busy;
  logic [NREGS-1:0] w_busy_next;

  always_comb begin
    w_busy_next = r_busy;
    for (int unsigned w = 0; w < NWRITE; w++) begin
      if (i_wen[w]) w_busy_next[i_waddr[w*AW +: AW]] = 1'b0;
    end
    if (i_issue && !(ZERO_REG && (i_issue_rd == '0))) w_busy_next[i_issue_rd] = 1'b1;
    if (i_sb_clear) w_busy_next = '0;
  end

  always_comb begin
    o_rbusy_next = '0;
    for (int unsigned p = 0; p < NREAD; p++) begin
      o_rbusy_next[p] = w_busy_next[i_raddr[p*AW +: AW]];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) r_busy <= '0;
    else       r_busy <= w_busy_next;
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file with registered read outputs.
// Read data/busy appear one edge after the address. Optional write-first
// bypass, hardwired-zero register 0, stall hold and flush bubble on the
// outputs; writes and the scoreboard ignore Stall/Flush.
// Ports:
//   Clock, Reset   rising-edge clock, synchronous active-high reset
//   Stall, Flush   hold / zero the read outputs (Flush wins)
//   Raddr          read addresses, port p at [p*AW +: AW]
//   Rdata, Rbusy   registered read data and pending-write flags
//   Wreg, Rd, Wdata  write enables, addresses, data per write port
//   Issue, IssueRd mark a destination pending in the scoreboard
//   SbClear        clear the whole scoreboard
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int unsigned XLEN     = DEF_XLEN,
  parameter int unsigned NREGS    = DEF_NREGS,
  parameter int unsigned NREAD    = 2,
  parameter int unsigned NWRITE   = 1,
  parameter bit          BYPASS   = 1'b1,
  parameter bit          ZERO_REG = 1'b1,
  localparam int unsigned AW      = addr_width(NREGS)
) (
  input  logic                    Clock,
  input  logic                    Reset,
  input  logic                    Stall,
  input  logic                    Flush,
  input  logic [NREAD*AW-1:0]     Raddr,
  output logic [NREAD*XLEN-1:0]   Rdata,
  output logic [NREAD-1:0]        Rbusy,
  input  logic [NWRITE-1:0]       Wreg,
  input  logic [NWRITE*AW-1:0]    Rd,
  input  logic [NWRITE*XLEN-1:0]  Wdata,
  input  logic                    Issue,
  input  logic [AW-1:0]           IssueRd,
  input  logic                    SbClear
);

  logic [XLEN-1:0]       r_regs [NREGS];
  logic [NREAD*XLEN-1:0] r_rdata;
  logic [NREAD-1:0]      r_rbusy;

  logic [NWRITE-1:0]     w_wen;
  logic [XLEN-1:0]       w_rval [NREAD];
  logic [NREAD-1:0]      w_rbusy_next;

  // Writes to a hardwired-zero register 0 are dropped entirely, so they
  // neither store, bypass, nor clear the scoreboard.
  always_comb begin
    w_wen = '0;
    for (int unsigned w = 0; w < NWRITE; w++) begin
      w_wen[w] = Wreg[w] && !(ZERO_REG && (Rd[w*AW +: AW] == '0));
    end
  end

  // Ascending port scan lets the highest-numbered matching write win.
  always_comb begin
    for (int unsigned p = 0; p < NREAD; p++) begin
      w_rval[p] = r_regs[Raddr[p*AW +: AW]];
      if (BYPASS) begin
        for (int unsigned w = 0; w < NWRITE; w++) begin
          if (w_wen[w] && (Rd[w*AW +: AW] == Raddr[p*AW +: AW]))
            w_rval[p] = Wdata[w*XLEN +: XLEN];
        end
      end
      if (ZERO_REG && (Raddr[p*AW +: AW] == '0)) w_rval[p] = '0;
    end
  end

  regfile_scoreboard #(
    .NREGS    (NREGS),
    .NREAD    (NREAD),
    .NWRITE   (NWRITE),
    .ZERO_REG (ZERO_REG),
    .AW       (AW)
  ) u_sb (
    .i_clk        (Clock),
    .i_rst        (Reset),
    .i_wen        (w_wen),
    .i_waddr      (Rd),
    .i_issue      (Issue),
    .i_issue_rd   (IssueRd),
    .i_sb_clear   (SbClear),
    .i_raddr      (Raddr),
    .o_rbusy_next (w_rbusy_next)
  );

  // Later loop iterations override earlier ones: port NWRITE-1 wins.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      for (int unsigned i = 0; i < NREGS; i++) r_regs[i] <= '0;
    end else begin
      for (int unsigned w = 0; w < NWRITE; w++) begin
        if (w_wen[w]) r_regs[Rd[w*AW +: AW]] <= Wdata[w*XLEN +: XLEN];
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset || Flush) begin
      r_rdata <= '0;
      r_rbusy <= '0;
    end else if (!Stall) begin
      for (int unsigned p = 0; p < NREAD; p++) begin
        r_rdata[p*XLEN +: XLEN] <= w_rval[p];
      end
      r_rbusy <= w_rbusy_next;
    end
  end

  assign Rdata = r_rdata;
  assign Rbusy = r_rbusy;

endmodule
